pipe_ex_mdu: RTL and testbench
==============================

// Module: pipe_ex_mdu
// PURPOSE
//  Iterative multiply/divide unit in the EX stage. It consumes the operand and
//  control outputs of the D/E pipeline register (ea, eb, MDU op) and owns the
//  HI/LO registers. It raises a stall so the front end holds the instruction
//  until the result is written. Supports MIPS32 mult, multu, div, divu, mthi, mtlo.
// PARAMETERS
//  WIDTH  32  operand width; one iteration per bit, so RUN lasts WIDTH cycles
// PORTS
//  clock    in   1      rising-edge clock
//  reset    in   1      asynchronous, active-high reset
//  estart   in   1      EX instruction is an MDU op; held while stall is high
//  eop      in   2      00 mult, 01 multu, 10 div, 11 divu
//  ea       in   WIDTH  rs operand (dividend / multiplicand)
//  eb       in   WIDTH  rt operand (divisor / multiplier)
//  eflush   in   1      kill the EX instruction; aborts any MDU operation
//  ehiwe    in   1      mthi: hi <= ea
//  elowe    in   1      mtlo: lo <= ea
//  stall    out  1      hold PC, F/D and D/E registers
//  done     out  1      one-cycle pulse; HI/LO hold the new result
//  hi       out  WIDTH  HI register
//  lo       out  WIDTH  LO register
// BEHAVIOUR
//  - Reset (asynchronous): state=IDLE, hi=lo=0, done=0, stall forced 0 while reset is high.
//  - States: IDLE, RUN, FIX.
//    IDLE->RUN when estart & ~done & ~eflush.
//    RUN->FIX after WIDTH iterations (cnt runs 0..WIDTH-1).
//    FIX->IDLE always.
//    Any state->IDLE on eflush (hi/lo unchanged, no done).
//  - Start edge (IDLE): latch magnitude |ea|,|eb| (unsigned op: raw values) and
//    sign bits sa, sb into a WIDTH+1-bit datapath, so |0x80000000| is exact. Latch eop.
//  - RUN, multiply: shift-add on a 2*WIDTH accumulator, one multiplier bit per cycle.
//  - RUN, divide: restoring divide, one quotient bit per cycle; remainder is WIDTH+1 bits.
//  - FIX: apply signs and write hi/lo; done=1 in the following cycle (registered).
//    Signed mult: 2*WIDTH product negated if sa^sb; {hi,lo}=product.
//    Signed div: quotient negated if sa^sb; remainder takes the sign of sa. lo=quot, hi=rem.
//    Divisor 0 (div or divu): lo=all ones, hi=original ea; full latency still applies.
//    0x80000000/-1: lo=0x80000000, hi=0 (wraps naturally, no trap).
//  - Latency: start sampled at edge E0, RUN on E1..E32, hi/lo written at E33.
//    done is high during the cycle after E33.
//  - stall (combinational) = (state!=IDLE) | (estart & state==IDLE & ~done), gated by
//    ~eflush & ~reset. In the done cycle stall=0, so the held instruction retires and is
//    not restarted.
//  - mthi/mtlo: applied only in IDLE (otherwise the stall holds them).
//    If ehiwe/elowe coincide with estart, the write takes effect and the op starts;
//    the FIX write later overwrites it.
//  - Back-to-back MDU ops: the next estart is accepted in the cycle after done.
// TESTING
//  1 multu ea=eb=0xFFFFFFFF -> stall high 33 cycles; hi=0xFFFFFFFE, lo=0x00000001; done 1 cycle
//  2 mult ea=0xFFFFFFFD(-3), eb=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF
//  3 divu 7/0 -> lo=0xFFFFFFFF, hi=0x00000007; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0
//  4 eflush at cycle 10 of RUN (hi=lo=0x1234 before) -> hi/lo stay 0x1234, no done, stall 0;
//    new estart next cycle starts cleanly
//  5 mtlo ea=0xA5A5A5A5 in IDLE -> lo=0xA5A5A5A5, stall 0; mthi while RUN -> ignored until IDLE
//  6 reset asserted asynchronously mid-RUN -> hi=lo=0, stall=0, done=0 before the next edge

Source files
------------

// File: rtl/pipe_ex_mdu.sv
// pipe_ex_mdu
// Iterative multiply/divide unit sitting in the EX stage. It takes the rs/rt
// operands and the MDU opcode from the D/E register, owns the HI/LO registers,
// and holds the front end with 'stall' until the result has been written.
// Supported operations: mult, multu, div, divu (via estart/eop), mthi, mtlo.
//
// Ports
//   clock   in  1      rising-edge clock
//   reset   in  1      asynchronous active-high reset
//   estart  in  1      EX instruction is an MDU op (held while stall is high)
//   eop     in  2      00 mult, 01 multu, 10 div, 11 divu
//   ea      in  WIDTH  rs operand (dividend / multiplicand, mthi/mtlo data)
//   eb      in  WIDTH  rt operand (divisor / multiplier)
//   eflush  in  1      kill the EX instruction, abort any running operation
//   ehiwe   in  1      mthi: hi <= ea
//   elowe   in  1      mtlo: lo <= ea
//   stall   out 1      hold PC, F/D and D/E registers
//   done    out 1      one-cycle pulse, HI/LO hold the new result
//   hi      out WIDTH  HI register
//   lo      out WIDTH  LO register

module pipe_ex_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             estart,
  input  logic [1:0]       eop,
  input  logic [WIDTH-1:0] ea,
  input  logic [WIDTH-1:0] eb,
  input  logic             eflush,
  input  logic             ehiwe,
  input  logic             elowe,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [1:0]         op_q;
  logic               sa_q;
  logic               sb_q;
  logic [WIDTH-1:0]   eaRaw_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH:0]     mplier_q;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH:0]     divisor_q;
  logic [WIDTH-1:0]   quot_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               signedOp;
  logic               saIn;
  logic               sbIn;
  logic [WIDTH:0]     aMag;
  logic [WIDTH:0]     bMag;
  logic               start;
  logic [WIDTH+1:0]   divShift;
  logic [WIDTH+1:0]   divDiff;
  logic               divGe;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH:0]     rem_d;
  logic [WIDTH-1:0]   quot_d;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH:0]     remFix;
  logic [WIDTH-1:0]   hiFix_d;
  logic [WIDTH-1:0]   loFix_d;

  // Operand magnitudes are WIDTH+1 bits wide so that the most negative value
  // has an exact magnitude. Unsigned ops pass the raw operands through.
  always_comb begin
    signedOp = ~eop[0];
    saIn     = signedOp & ea[WIDTH-1];
    sbIn     = signedOp & eb[WIDTH-1];
    aMag     = saIn ? -{ea[WIDTH-1], ea} : {1'b0, ea};
    bMag     = sbIn ? -{eb[WIDTH-1], eb} : {1'b0, eb};
    start    = (state_q == IDLE) & estart & ~done_q & ~eflush;
  end

  // One iteration of both datapaths. Multiply adds the shifted multiplicand
  // when the current multiplier bit is set; divide is a restoring step that
  // shifts the next dividend bit into the partial remainder. Both advance
  // every RUN cycle and the FIX stage picks whichever matches the opcode.
  always_comb begin
    prod_d   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    divShift = {rem_q, quot_q[WIDTH-1]};
    divGe    = divShift >= {1'b0, divisor_q};
    divDiff  = divShift - {1'b0, divisor_q};
    rem_d    = divGe ? (WIDTH+1)'(divDiff) : (WIDTH+1)'(divShift);
    quot_d   = {quot_q[WIDTH-2:0], divGe};
  end

  // Sign correction and HI/LO selection for the FIX cycle. A zero divisor
  // leaves an all-ones quotient and returns the original dividend as HI.
  // The most-negative / -1 case wraps through the negation without a trap.
  always_comb begin
    prodFix = (sa_q ^ sb_q) ? -prod_q : prod_q;
    quotFix = (sa_q ^ sb_q) ? -quot_q : quot_q;
    remFix  = sa_q ? -rem_q : rem_q;
    if (!op_q[1]) begin
      hiFix_d = prodFix[2*WIDTH-1:WIDTH];
      loFix_d = prodFix[WIDTH-1:0];
    end else if (divisor_q == '0) begin
      hiFix_d = eaRaw_q;
      loFix_d = '1;
    end else begin
      hiFix_d = WIDTH'(remFix);
      loFix_d = quotFix;
    end
  end

  // Control FSM with HI/LO and done registered alongside it. A flush returns
  // to IDLE from any state without touching HI/LO; mthi/mtlo only land while
  // IDLE because the stall holds them in the pipeline otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      eaRaw_q   <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      quot_q    <= '0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (eflush) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (ehiwe) hi_q <= ea;
            if (elowe) lo_q <= ea;
            if (start) begin
              state_q   <= RUN;
              cnt_q     <= '0;
              op_q      <= eop;
              sa_q      <= saIn;
              sb_q      <= sbIn;
              eaRaw_q   <= ea;
              prod_q    <= '0;
              mcand_q   <= {{(WIDTH-1){1'b0}}, aMag};
              mplier_q  <= bMag;
              rem_q     <= '0;
              divisor_q <= bMag;
              quot_q    <= aMag[WIDTH-1:0];
            end
          end
          RUN: begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LAST) state_q <= FIX;
          end
          FIX: begin
            hi_q    <= hiFix_d;
            lo_q    <= loFix_d;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // In the done cycle the still-presented instruction is allowed to retire
  // rather than being started a second time.
  assign stall = ((state_q != IDLE) | (estart & ~done_q)) & ~eflush & ~reset;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_pipe_ex_mdu.sv
// Directed testbench for pipe_ex_mdu: every expected value below is worked
// out by hand from the operands and checked through checkOutput.

module tb_pipe_ex_mdu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        estart = 1'b0;
  logic [1:0]  eop = 2'b00;
  logic [31:0] ea = '0;
  logic [31:0] eb = '0;
  logic        eflush = 1'b0;
  logic        ehiwe = 1'b0;
  logic        elowe = 1'b0;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int testCount = 0;
  int failCount = 0;

  pipe_ex_mdu #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .estart(estart),
    .eop   (eop),
    .ea    (ea),
    .eb    (eb),
    .eflush(eflush),
    .ehiwe (ehiwe),
    .elowe (elowe),
    .stall (stall),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // 100 MHz-style free-running clock
  always #5 clock = ~clock;

  // Single comparison point: counts every check, reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Samples on falling edges until done pulses, counting stall-high cycles
  task automatic waitDone(output int stallCycles, output logic seen);
    stallCycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
      else if (stall) stallCycles++;
    end
  endtask

  // Runs one MDU op end to end and checks latency, stall, done pulse and HI/LO
  task automatic applyStimulus(input string tag, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expHi, input logic [31:0] expLo);
    int   stallCycles;
    logic seen;
    @(negedge clock);
    estart = 1'b1;
    eop    = op;
    ea     = a;
    eb     = b;
    #1 checkOutput({tag, " stall_at_start"}, 64'(stall), 64'd1);
    @(posedge clock);
    waitDone(stallCycles, seen);
    checkOutput({tag, " done_seen"}, 64'(seen), 64'd1);
    checkOutput({tag, " stall_cycles"}, 64'(stallCycles), 64'd33);
    checkOutput({tag, " stall_in_done"}, 64'(stall), 64'd0);
    checkOutput({tag, " hi"}, 64'(hi), 64'(expHi));
    checkOutput({tag, " lo"}, 64'(lo), 64'(expLo));
    @(posedge clock);
    #1 estart = 1'b0;
    @(negedge clock);
    checkOutput({tag, " done_one_cycle"}, 64'(done), 64'd0);
    checkOutput({tag, " no_restart"}, 64'(stall), 64'd0);
  endtask

  // Main directed sequence
  initial begin
    int   stallCycles;
    int   doneHits;
    logic seen;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset hi", 64'(hi), 64'd0);
    checkOutput("reset lo", 64'(lo), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset stall", 64'(stall), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Arithmetic vectors, including back-to-back starts
    applyStimulus("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    applyStimulus("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    applyStimulus("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    applyStimulus("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    applyStimulus("mult_minxmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    applyStimulus("div_7dm2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    applyStimulus("divu_7d0", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    applyStimulus("div_m7d0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    applyStimulus("div_mind_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // Flush in the middle of RUN: HI/LO preserved, no done, clean restart
    @(negedge clock);
    ea = 32'h1234;
    ehiwe = 1'b1;
    elowe = 1'b1;
    @(posedge clock);
    #1 ehiwe = 1'b0;
    elowe = 1'b0;
    @(negedge clock);
    checkOutput("mthi_mtlo hi", 64'(hi), 64'h1234);
    estart = 1'b1;
    eop = 2'b01;
    ea = 32'd5;
    eb = 32'd5;
    @(posedge clock);
    repeat (10) @(posedge clock);
    @(negedge clock);
    eflush = 1'b1;
    #1 checkOutput("flush stall", 64'(stall), 64'd0);
    @(posedge clock);
    #1 eflush = 1'b0;
    estart = 1'b0;
    doneHits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) doneHits++;
    end
    checkOutput("flush no_done", 64'(doneHits), 64'd0);
    checkOutput("flush stall_after", 64'(stall), 64'd0);
    checkOutput("flush hi", 64'(hi), 64'h1234);
    checkOutput("flush lo", 64'(lo), 64'h1234);
    applyStimulus("after_flush", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30);

    // mtlo in IDLE applies immediately without stalling
    @(negedge clock);
    ea = 32'hA5A5_A5A5;
    elowe = 1'b1;
    #1 checkOutput("mtlo stall", 64'(stall), 64'd0);
    @(posedge clock);
    #1 elowe = 1'b0;
    @(negedge clock);
    checkOutput("mtlo lo", 64'(lo), 64'hA5A5_A5A5);
    checkOutput("mtlo hi_kept", 64'(hi), 64'd0);

    // mthi while RUN is ignored; the result overwrites HI afterwards
    estart = 1'b1;
    eop = 2'b01;
    ea = 32'd2;
    eb = 32'd3;
    @(posedge clock);
    @(negedge clock);
    ea = 32'hDEAD;
    ehiwe = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    ehiwe = 1'b0;
    checkOutput("mthi_in_run hi", 64'(hi), 64'd0);
    waitDone(stallCycles, seen);
    checkOutput("mthi_in_run done", 64'(seen), 64'd1);
    checkOutput("mthi_in_run res_hi", 64'(hi), 64'd0);
    checkOutput("mthi_in_run res_lo", 64'(lo), 64'd6);
    @(posedge clock);
    #1 estart = 1'b0;

    // Asynchronous reset in the middle of RUN clears everything before the next edge
    @(negedge clock);
    estart = 1'b1;
    eop = 2'b01;
    ea = 32'hFFFF;
    eb = 32'hFFFF;
    @(posedge clock);
    repeat (5) @(posedge clock);
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    checkOutput("async_reset hi", 64'(hi), 64'd0);
    checkOutput("async_reset lo", 64'(lo), 64'd0);
    checkOutput("async_reset stall", 64'(stall), 64'd0);
    checkOutput("async_reset done", 64'(done), 64'd0);
    estart = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("after_reset stall", 64'(stall), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
